// File: rtl/dkong_input_pkg.sv
// Shared types and constants for the Donkey Kong cabinet input conditioner.
// Holds the coin FSM state encoding and the channel numbering.
package dkong_input_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        LOCKOUT
    } coin_state_t;

    localparam int CH_P1   = 0;
    localparam int CH_P2   = 1;
    localparam int CH_COIN = 2;
    localparam int NUM_CH  = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dkong_input_cond_if.sv
// Cabinet switch bundle: raw switch levels in, conditioned levels and coin pulse out.
// The master side is the cabinet/harness, the slave side is the conditioner.
interface dkong_input_cond_if;

    logic       p1_raw;
    logic       p2_raw;
    logic       coin_raw;
    logic       p1_sw;
    logic       p2_sw;
    logic       coin_sw;
    logic [7:0] coin_count;

    modport master (
        output p1_raw, p2_raw, coin_raw,
        input  p1_sw, p2_sw, coin_sw, coin_count
    );

    modport slave (
        input  p1_raw, p2_raw, coin_raw,
        output p1_sw, p2_sw, coin_sw, coin_count
    );

endinterface

// File: rtl/dkong_debounce.sv
// One switch channel: two-flop synchroniser followed by a debounce counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive cycles of agreement.
module dkong_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic masterclk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Any disagreement shorter than the full window restarts the count from zero.
    always_ff @(posedge masterclk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign dout = stable;

endmodule

// File: rtl/dkong_input_cond.sv
// Conditions the P1/P2 start and coin switches for dkong_system: synchronise,
// debounce, and turn each accepted coin into one fixed-width pulse with lockout.
module dkong_input_cond
    import dkong_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 65536,
    parameter int COIN_PULSE_CYCLES   = 4096,
    parameter int COIN_LOCKOUT_CYCLES = 262144,
    parameter bit RAW_ACTIVE_LOW      = 1'b1
) (
    input logic               masterclk,
    input logic               rst_n,
    dkong_input_cond_if.slave io
);

    localparam int TW = $clog2(max_int(COIN_PULSE_CYCLES, COIN_LOCKOUT_CYCLES)) + 1;
    localparam logic [TW-1:0] PULSE_LOAD = TW'(COIN_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD  =
        TW'((COIN_LOCKOUT_CYCLES > 0) ? COIN_LOCKOUT_CYCLES - 1 : 0);

    logic [NUM_CH-1:0] raw_hi;
    logic [NUM_CH-1:0] stable;
    logic              coin_prev;
    logic              coin_rise;
    coin_state_t       state;
    logic [TW-1:0]     timer;
    logic              coin_pulse;
    logic [7:0]        count;

    assign raw_hi[CH_P1]   = io.p1_raw   ^ RAW_ACTIVE_LOW;
    assign raw_hi[CH_P2]   = io.p2_raw   ^ RAW_ACTIVE_LOW;
    assign raw_hi[CH_COIN] = io.coin_raw ^ RAW_ACTIVE_LOW;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        dkong_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .masterclk(masterclk),
            .rst_n    (rst_n),
            .din      (raw_hi[ch]),
            .dout     (stable[ch])
        );
    end

    assign coin_rise = stable[CH_COIN] & ~coin_prev;

    // Rises seen outside IDLE are simply dropped, so a held or bouncing coin
    // can never queue a second pulse.
    always_ff @(posedge masterclk or negedge rst_n) begin
        if (!rst_n) begin
            coin_prev  <= 1'b0;
            state      <= IDLE;
            timer      <= '0;
            coin_pulse <= 1'b0;
            count      <= '0;
        end else begin
            coin_prev <= stable[CH_COIN];
            unique case (state)
                IDLE: begin
                    if (coin_rise) begin
                        state      <= PULSE;
                        timer      <= PULSE_LOAD;
                        coin_pulse <= 1'b1;
                        count      <= count + 1'b1;
                    end
                end
                PULSE: begin
                    if (timer == '0) begin
                        coin_pulse <= 1'b0;
                        if (COIN_LOCKOUT_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= LOCKOUT;
                            timer <= LOCK_LOAD;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (timer == '0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    coin_pulse <= 1'b0;
                end
            endcase
        end
    end

    assign io.p1_sw      = stable[CH_P1];
    assign io.p2_sw      = stable[CH_P2];
    assign io.coin_sw    = coin_pulse;
    assign io.coin_count = count;

endmodule

// File: tb/tb_dkong_input_cond.sv
// Directed bench for dkong_input_cond with short debounce/pulse/lockout windows.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dkong_input_cond;

    localparam int DEB  = 4;
    localparam int PUL  = 3;
    localparam int LOCK = 5;

    logic masterclk;
    logic rst_n;
    int   num_compared   = 0;
    int   num_mismatched = 0;

    dkong_input_cond_if io ();

    dkong_input_cond #(
        .DEBOUNCE_CYCLES    (DEB),
        .COIN_PULSE_CYCLES  (PUL),
        .COIN_LOCKOUT_CYCLES(LOCK),
        .RAW_ACTIVE_LOW     (1'b1)
    ) dut (
        .masterclk(masterclk),
        .rst_n    (rst_n),
        .io       (io)
    );

    initial masterclk = 1'b0;
    always #5 masterclk = ~masterclk;

    task automatic apply_stimulus(input bit p1, input bit p2, input bit coin);
        io.p1_raw   = p1;
        io.p2_raw   = p2;
        io.coin_raw = coin;
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        num_compared++;
        assert (observed === expected) else begin
            num_mismatched++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        num_compared++;
        assert (observed === expected) else begin
            num_mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset with all switches released (raw high = inactive)
        rst_n = 1'b0;
        apply_stimulus(1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge masterclk);
        check_bit ("reset_p1", io.p1_sw, 1'b0);
        check_bit ("reset_p2", io.p2_sw, 1'b0);
        check_bit ("reset_coin", io.coin_sw, 1'b0);
        check_byte("reset_count", io.coin_count, 8'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge masterclk);
        check_bit ("idle_p1", io.p1_sw, 1'b0);
        check_bit ("idle_coin", io.coin_sw, 1'b0);

        // P1 press: level appears DEB+1 edges after the change is sampled
        $display("[TB] P1 press/release");
        apply_stimulus(1'b0, 1'b1, 1'b1);
        for (int j = 1; j <= 7; j++) begin
            @(negedge masterclk);
            check_bit("p1_press", io.p1_sw, j >= 6);
            check_bit("p1_press_p2", io.p2_sw, 1'b0);
        end
        repeat (5) @(negedge masterclk);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        for (int j = 1; j <= 7; j++) begin
            @(negedge masterclk);
            check_bit("p1_release", io.p1_sw, j < 6);
        end

        // P2 glitch of DEB-1 cycles is rejected
        $display("[TB] P2 glitch");
        apply_stimulus(1'b1, 1'b0, 1'b1);
        for (int j = 1; j <= 12; j++) begin
            @(negedge masterclk);
            if (j == 3) apply_stimulus(1'b1, 1'b1, 1'b1);
            check_bit("p2_glitch", io.p2_sw, 1'b0);
        end

        // Single held coin: one 3-cycle pulse starting at edge k+6
        $display("[TB] single coin");
        apply_stimulus(1'b1, 1'b1, 1'b0);
        for (int j = 1; j <= 30; j++) begin
            @(negedge masterclk);
            if (j == 20) apply_stimulus(1'b1, 1'b1, 1'b1);
            check_bit ("coin_single_sw", io.coin_sw, (j >= 7) && (j <= 9));
            check_byte("coin_single_cnt", io.coin_count, (j >= 7) ? 8'd1 : 8'd0);
        end
        repeat (5) @(negedge masterclk);

        // Minimal-gap second press whose debounced rise lands on the last LOCKOUT cycle
        $display("[TB] lockout");
        for (int j = 0; j < 30; j++) begin
            apply_stimulus(1'b1, 1'b1, !((j < 4) || ((j >= 8) && (j < 20))));
            @(negedge masterclk);
            check_bit ("lock_sw", io.coin_sw, ((j + 1) >= 7) && ((j + 1) <= 9));
            check_byte("lock_cnt", io.coin_count, ((j + 1) >= 7) ? 8'd2 : 8'd1);
        end
        repeat (5) @(negedge masterclk);

        // Press after lockout has ended is accepted again
        for (int j = 0; j < 20; j++) begin
            apply_stimulus(1'b1, 1'b1, !(j < 8));
            @(negedge masterclk);
            check_bit ("after_lock_sw", io.coin_sw, ((j + 1) >= 7) && ((j + 1) <= 9));
            check_byte("after_lock_cnt", io.coin_count, ((j + 1) >= 7) ? 8'd3 : 8'd2);
        end
        repeat (5) @(negedge masterclk);

        // Wrap: 253 more coins take the count from 3 through 255 to 0
        $display("[TB] count wrap");
        for (int n = 0; n < 253; n++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0);
            repeat (5) @(negedge masterclk);
            apply_stimulus(1'b1, 1'b1, 1'b1);
            repeat (12) @(negedge masterclk);
            if (n == 251) check_byte("wrap_255", io.coin_count, 8'd255);
        end
        check_byte("wrap_zero", io.coin_count, 8'd0);

        // Simultaneous press on all three channels
        $display("[TB] simultaneous press");
        apply_stimulus(1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 10; j++) begin
            @(negedge masterclk);
            check_bit ("sim_p1", io.p1_sw, j >= 6);
            check_bit ("sim_p2", io.p2_sw, j >= 6);
            check_bit ("sim_coin", io.coin_sw, (j >= 7) && (j <= 9));
            check_byte("sim_cnt", io.coin_count, (j >= 7) ? 8'd1 : 8'd0);
        end
        apply_stimulus(1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge masterclk);

        // Asynchronous reset in the middle of a coin pulse
        $display("[TB] reset mid-pulse");
        apply_stimulus(1'b0, 1'b1, 1'b0);
        repeat (7) @(negedge masterclk);
        check_bit ("pre_rst_coin", io.coin_sw, 1'b1);
        check_bit ("pre_rst_p1", io.p1_sw, 1'b1);
        check_byte("pre_rst_cnt", io.coin_count, 8'd2);
        rst_n = 1'b0;
        #1;
        check_bit ("async_rst_p1", io.p1_sw, 1'b0);
        check_bit ("async_rst_p2", io.p2_sw, 1'b0);
        check_bit ("async_rst_coin", io.coin_sw, 1'b0);
        check_byte("async_rst_cnt", io.coin_count, 8'd0);

        // Switches still held at reset release count as a fresh press
        @(negedge masterclk);
        rst_n = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge masterclk);
            check_bit ("held_p1", io.p1_sw, j >= 6);
            check_bit ("held_coin", io.coin_sw, (j >= 7) && (j <= 9));
            check_byte("held_cnt", io.coin_count, (j >= 7) ? 8'd1 : 8'd0);
        end
        apply_stimulus(1'b1, 1'b1, 1'b1);
        repeat (5) @(negedge masterclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
